mirrored_ram: RTL and testbench

MIRRORED_RAM -- requirements
Module: mirrored_ram

---
 rtl/mirrored_ram.sv | 153 +++++++++++++++
 tb/tb_mirrored_ram.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mirrored_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mirrored_ram : single-port RAM decoded into an aliased address region, with
//                a FILL sweep after reset and a saturating rejected-write count.
// Revision     : 1.0
// ---------------------------------------------------------------------------
module mirrored_ram #(
  parameter int                ADDR_W        = 16,
  parameter int                DATA_W        = 8,
  parameter int                DEPTH_LOG2    = 11,
  parameter logic [ADDR_W-1:0] BASE          = '0,
  parameter int                REGION_LOG2   = 13,
  parameter int                RD_LATENCY    = 1,
  parameter bit                WRITE_PROTECT = 1'b0,
  parameter logic [DATA_W-1:0] FILL          = '0
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              sel,
  output logic              busy,
  output logic [7:0]        fault_count
);

  if (!(DEPTH_LOG2 <= REGION_LOG2 && REGION_LOG2 <= ADDR_W &&
        (RD_LATENCY == 1 || RD_LATENCY == 2))) begin : g_param_check
    $error("mirrored_ram: illegal parameter combination");
  end

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [DEPTH_LOG2-1:0] c_last_ptr = '1;

  logic [DATA_W-1:0]     mem [0:(2**DEPTH_LOG2)-1];

  state_t                r_state;
  state_t                w_state_next;
  logic [DEPTH_LOG2-1:0] r_ptr;
  logic [DEPTH_LOG2-1:0] w_ptr_next;
  logic [DATA_W-1:0]     r_s1_data;
  logic [DATA_W-1:0]     w_s1_data_next;
  logic                  r_s1_sel;
  logic                  w_s1_sel_next;
  logic [7:0]            r_fault;
  logic                  w_fault;
  logic                  w_hit;
  logic [DEPTH_LOG2-1:0] w_index;
  logic                  w_mem_we;
  logic [DEPTH_LOG2-1:0] w_mem_waddr;
  logic [DATA_W-1:0]     w_mem_wdata;
  logic                  w_unused_addr;

  // Region decode; when the region spans the whole address space every access hits.
  if (REGION_LOG2 < ADDR_W) begin : g_decode
    assign w_hit = (addr[ADDR_W-1:REGION_LOG2] == BASE[ADDR_W-1:REGION_LOG2]);
  end else begin : g_full_decode
    assign w_hit = 1'b1;
  end

  assign w_index       = addr[DEPTH_LOG2-1:0];
  assign w_unused_addr = ^addr;

  always_comb begin
    w_state_next   = r_state;
    w_ptr_next     = r_ptr;
    w_mem_we       = 1'b0;
    w_mem_waddr    = w_index;
    w_mem_wdata    = data_in;
    w_s1_data_next = '0;
    w_s1_sel_next  = 1'b0;
    w_fault        = 1'b0;
    case (r_state)
      CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_ptr;
        w_mem_wdata = FILL;
        w_ptr_next  = r_ptr + 1'b1;
        w_fault     = w_hit && !rw;
        if (r_ptr == c_last_ptr) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_hit) begin
          w_s1_sel_next = 1'b1;
          if (rw) begin
            w_s1_data_next = mem[w_index];
          end else if (WRITE_PROTECT) begin
            w_fault = 1'b1;
          end else begin
            w_mem_we = 1'b1;
          end
        end
      end
      default: w_state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state   <= CLEAR;
      r_ptr     <= '0;
      r_s1_data <= '0;
      r_s1_sel  <= 1'b0;
      r_fault   <= 8'd0;
    end else begin
      r_state   <= w_state_next;
      r_ptr     <= w_ptr_next;
      r_s1_data <= w_s1_data_next;
      r_s1_sel  <= w_s1_sel_next;
      if (w_fault && r_fault != 8'hFF) begin
        r_fault <= r_fault + 8'd1;
      end
    end
  end

  // Array itself is not reset; the sweep provides its defined contents.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_W-1:0] r_s2_data;
    logic              r_s2_sel;
    always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
        r_s2_data <= '0;
        r_s2_sel  <= 1'b0;
      end else begin
        r_s2_data <= r_s1_data;
        r_s2_sel  <= r_s1_sel;
      end
    end
    assign data_out = r_s2_data;
    assign sel      = r_s2_sel;
  end else begin : g_lat1
    assign data_out = r_s1_data;
    assign sel      = r_s1_sel;
  end

  assign busy        = (r_state == CLEAR);
  assign fault_count = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mirrored_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mirrored_ram : self-checking bench for mirrored_ram (three configurations).
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_mirrored_ram;

  logic        clock = 1'b0;
  logic        nreset;

  logic [15:0] a0, a2, a3;
  logic        rw0, rw2, rw3;
  logic [7:0]  d0, d2, d3;
  logic [7:0]  q0, q2, q3;
  logic        s0, s2, s3;
  logic        b0, b2, b3;
  logic [7:0]  f0, f2, f3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  mirrored_ram dut0 (
    .clock(clock), .nreset(nreset), .addr(a0), .rw(rw0), .data_in(d0),
    .data_out(q0), .sel(s0), .busy(b0), .fault_count(f0)
  );

  mirrored_ram #(.RD_LATENCY(2)) dut2 (
    .clock(clock), .nreset(nreset), .addr(a2), .rw(rw2), .data_in(d2),
    .data_out(q2), .sel(s2), .busy(b2), .fault_count(f2)
  );

  mirrored_ram #(.WRITE_PROTECT(1'b1), .BASE(16'h8000), .REGION_LOG2(15)) dut3 (
    .clock(clock), .nreset(nreset), .addr(a3), .rw(rw3), .data_in(d3),
    .data_out(q3), .sel(s3), .busy(b3), .fault_count(f3)
  );

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  din;
    logic [7:0]  exp_data;
    logic        exp_sel;
  } vec_t;

  vec_t       vecs [12];
  logic [7:0] ref_mem [2048];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: default configuration decodes 0x0000-0x1FFF, 2048 physical words.
  function automatic bit ref_hit(input logic [15:0] a);
    return a[15:13] == 3'b000;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    logic [15:0] ra;
    logic        rrw;
    logic [7:0]  rd, exp_d;
    logic        exp_s;

    vecs[0]  = '{16'h0123, 1'b0, 8'h5A, 8'h00, 1'b1};
    vecs[1]  = '{16'h0923, 1'b1, 8'h00, 8'h5A, 1'b1};
    vecs[2]  = '{16'h1123, 1'b1, 8'h00, 8'h5A, 1'b1};
    vecs[3]  = '{16'h1923, 1'b1, 8'h00, 8'h5A, 1'b1};
    vecs[4]  = '{16'h2123, 1'b1, 8'h00, 8'h00, 1'b0};
    vecs[5]  = '{16'h2123, 1'b0, 8'h11, 8'h00, 1'b0};
    vecs[6]  = '{16'h0123, 1'b1, 8'h00, 8'h5A, 1'b1};
    vecs[7]  = '{16'h07FF, 1'b0, 8'h3C, 8'h00, 1'b1};
    vecs[8]  = '{16'h1FFF, 1'b1, 8'h00, 8'h3C, 1'b1};
    vecs[9]  = '{16'hE7FF, 1'b1, 8'h00, 8'h00, 1'b0};
    vecs[10] = '{16'h0000, 1'b0, 8'hC3, 8'h00, 1'b1};
    vecs[11] = '{16'h1800, 1'b1, 8'h00, 8'hC3, 1'b1};

    nreset = 1'b0;
    a0 = 16'h0005; rw0 = 1'b1; d0 = 8'h00;
    a2 = 16'h0000; rw2 = 1'b1; d2 = 8'h00;
    a3 = 16'h0000; rw3 = 1'b1; d3 = 8'h00;
    #23;
    check("reset_busy",  32'(b0), 32'd1);
    check("reset_sel",   32'(s0), 32'd0);
    check("reset_data",  32'(q0), 32'd0);
    check("reset_fault", 32'(f0), 32'd0);

    // First sweep: three rejected writes, then reset again at sweep edge 1000.
    @(posedge clock); #1;
    nreset = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if (i == 100) begin
        check("clear_sel",  32'(s0), 32'd0);
        check("clear_data", 32'(q0), 32'd0);
      end
      if (i == 10 || i == 20 || i == 30) begin
        rw0 = 1'b0; d0 = 8'h77;
      end else begin
        rw0 = 1'b1;
      end
    end
    check("fault_pre_reset", 32'(f0), 32'd3);
    #2;
    nreset = 1'b0;
    #1;
    check("async_fault", 32'(f0), 32'd0);
    check("async_busy",  32'(b0), 32'd1);
    check("async_data",  32'(q0), 32'd0);
    repeat (3) tick();
    nreset = 1'b1;

    // Second sweep: measure its length; one rejected write to 0x0005 inside it.
    cnt = 0;
    for (int i = 1; i <= 3000; i++) begin
      tick();
      cnt = i;
      if (!b0) break;
      if (i == 5) begin
        a0 = 16'h0005; rw0 = 1'b0; d0 = 8'h77;
      end else begin
        rw0 = 1'b1;
      end
    end
    check("sweep_len",       32'(cnt), 32'd2048);
    check("sweep_busy_lat2", 32'(b2),  32'd0);
    check("sweep_busy_wp",   32'(b3),  32'd0);
    check("clear_fault",     32'(f0),  32'd1);

    for (int i = 0; i < 2048; i++) begin
      a0 = 16'(i); rw0 = 1'b1;
      tick();
      check("readback_data", 32'(q0), 32'd0);
      check("readback_sel",  32'(s0), 32'd1);
      ref_mem[i] = 8'h00;
    end

    for (int i = 0; i < 12; i++) begin
      a0 = vecs[i].addr; rw0 = vecs[i].rw; d0 = vecs[i].din;
      if (ref_hit(vecs[i].addr) && !vecs[i].rw) ref_mem[vecs[i].addr[10:0]] = vecs[i].din;
      tick();
      check($sformatf("vec%0d_data", i), 32'(q0), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_sel", i),  32'(s0), 32'(vecs[i].exp_sel));
    end

    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 3) != 0) ra[15:13] = 3'b000;
      if ($urandom_range(0, 1) == 1) ra[10:4] = 7'd0;
      rrw = 1'($urandom_range(0, 1));
      rd  = 8'($urandom);
      exp_d = 8'h00;
      exp_s = ref_hit(ra);
      if (exp_s && rrw) exp_d = ref_mem[ra[10:0]];
      if (exp_s && !rrw) ref_mem[ra[10:0]] = rd;
      a0 = ra; rw0 = rrw; d0 = rd;
      tick();
      check("rand_data", 32'(q0), 32'(exp_d));
      check("rand_sel",  32'(s0), 32'(exp_s));
    end
    check("rand_fault_unchanged", 32'(f0), 32'd1);
    rw0 = 1'b1;

    // Two-stage read pipeline: write then immediate read of the same word.
    a2 = 16'h0010; rw2 = 1'b0; d2 = 8'hA5;
    tick();
    rw2 = 1'b1;
    tick();
    check("lat2_prev_data", 32'(q2), 32'd0);
    tick();
    check("lat2_data", 32'(q2), 32'hA5);
    check("lat2_sel",  32'(s2), 32'd1);

    // Write-protected instance: saturating fault count, array untouched.
    a3 = 16'h8000; rw3 = 1'b0; d3 = 8'hFF;
    repeat (300) tick();
    check("wp_fault_sat", 32'(f3), 32'd255);
    a3 = 16'h0000;
    tick();
    check("wp_miss_fault", 32'(f3), 32'd255);
    check("wp_miss_sel",   32'(s3), 32'd0);
    a3 = 16'h8000; rw3 = 1'b1;
    tick();
    check("wp_read_data", 32'(q3), 32'd0);
    check("wp_read_sel",  32'(s3), 32'd1);

    // Asynchronous reset while a read result is on the output.
    a0 = 16'h0001; rw0 = 1'b0; d0 = 8'h99;
    tick();
    rw0 = 1'b1;
    tick();
    check("pre_reset_data", 32'(q0), 32'h99);
    #3;
    nreset = 1'b0;
    #1;
    check("async2_data",  32'(q0), 32'd0);
    check("async2_sel",   32'(s0), 32'd0);
    check("async2_busy",  32'(b0), 32'd1);
    check("async2_fault", 32'(f0), 32'd0);
    check("async2_wp_fault", 32'(f3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
